computie_snoop_sequencer: RTL

Host-command sequencer for the Computie bus snooper, on the `comm_clock` side of the snooper. It takes single-byte ASCII commands from the UART receiver and drives the snooper's `record_start`, `record_trigger` and `dump_start` controls. It shares the UART transmitter between the snooper's dump byte stream and its own status responses.

---
 rtl/computie_snoop_pkg.sv | 31 +++
 rtl/computie_snoop_sequencer_if.sv | 32 +++
 rtl/computie_snoop_timeout.sv | 37 +++
 rtl/computie_snoop_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/computie_snoop_pkg.sv
// Shared types and byte constants for the Computie snooper host-command sequencer.
package computie_snoop_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecord,
    StDump,
    StRespCode,
    StRespNl
  } seq_state_e;

  localparam logic [7:0] CmdRecord  = 8'h52;  // 'R'
  localparam logic [7:0] CmdDump    = 8'h44;  // 'D'
  localparam logic [7:0] CmdTrigger = 8'h54;  // 'T'
  localparam logic [7:0] CmdAbort   = 8'h58;  // 'X'

  localparam logic [7:0] RespOk      = 8'h4B;  // 'K'
  localparam logic [7:0] RespError   = 8'h45;  // 'E'
  localparam logic [7:0] RespAbort   = 8'h41;  // 'A'
  localparam logic [7:0] RespTimeout = 8'h4F;  // 'O'

  localparam logic [7:0] CharLf    = 8'h0A;
  localparam logic [7:0] CharCr    = 8'h0D;
  localparam logic [7:0] CharSpace = 8'h20;

  // Whitespace a terminal emits between commands; silently ignored when idle.
  function automatic logic is_blank(input logic [7:0] b);
    return (b == CharCr) || (b == CharLf) || (b == CharSpace);
  endfunction

endpackage

// File: rtl/computie_snoop_sequencer_if.sv
// Command, response, snooper-control and dump streams around the sequencer.
interface computie_snoop_sequencer_if;

  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       record_start;
  logic       record_end;
  logic       record_trigger;
  logic       dump_start;
  logic       dump_end;
  logic       snoop_valid;
  logic       snoop_ready;
  logic [7:0] snoop_data;
  logic       busy;

  modport master (
    input  rx_valid, rx_data, tx_ready, record_end, dump_end, snoop_valid, snoop_data,
    output rx_ready, tx_valid, tx_data, record_start, record_trigger, dump_start,
    output snoop_ready, busy
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, record_end, dump_end, snoop_valid, snoop_data,
    input  rx_ready, tx_valid, tx_data, record_start, record_trigger, dump_start,
    input  snoop_ready, busy
  );

endinterface

// File: rtl/computie_snoop_timeout.sv
// Saturating arm-timeout counter; expired flags the last permitted cycle while enabled.
module computie_snoop_timeout #(
  parameter int unsigned Limit = 1_000_000
) (
  input  logic comm_clock,
  input  logic comm_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned Width = (Limit == 0) ? 1 : $clog2(Limit + 1);
  localparam logic [Width-1:0] Last = Width'((Limit == 0) ? 0 : Limit - 1);
  localparam logic [Width-1:0] Max = '1;

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Max)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (Limit != 0) && enable && (count_q == Last);

endmodule

// File: rtl/computie_snoop_sequencer.sv
// Host-command sequencer: decodes UART command bytes, drives record/dump controls and
// shares the UART transmitter between the dump stream and its own status responses.
module computie_snoop_sequencer
  import computie_snoop_pkg::*;
#(
  parameter int unsigned ARM_TIMEOUT = 1_000_000
) (
  input logic                         comm_clock,
  input logic                         comm_reset,
  computie_snoop_sequencer_if.master  bus
);

  seq_state_e state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       trigger_q, trigger_d;
  logic [1:0] guard_q, guard_d;

  logic       rx_ready, rx_fire;
  logic       tx_valid, tx_fire, snoop_ready;
  logic [7:0] tx_data;
  logic       tmo_clear, tmo_expired, in_record;

  assign in_record = (state_q == StRecord);
  assign rx_ready  = (state_q == StIdle) || in_record;
  assign rx_fire   = bus.rx_valid && rx_ready;
  assign tx_fire   = tx_valid && bus.tx_ready;

  computie_snoop_timeout #(
    .Limit (ARM_TIMEOUT)
  ) u_timeout (
    .comm_clock (comm_clock),
    .comm_reset (comm_reset),
    .clear      (tmo_clear),
    .enable     (in_record),
    .expired    (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    trigger_d = 1'b0;
    guard_d   = guard_q;
    tmo_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (bus.rx_data == CmdRecord) begin
            state_d   = StRecord;
            tmo_clear = 1'b1;
          end else if (bus.rx_data == CmdDump) begin
            state_d = StDump;
            guard_d = 2'd0;
          end else if (!is_blank(bus.rx_data)) begin
            state_d = StRespCode;
            code_d  = RespError;
          end
        end
      end
      StRecord: begin
        // Buffer full outranks an abort, which outranks the timeout.
        if (bus.record_end) begin
          state_d = StRespCode;
          code_d  = RespOk;
        end else if (rx_fire && (bus.rx_data == CmdAbort)) begin
          state_d = StRespCode;
          code_d  = RespAbort;
        end else if (tmo_expired) begin
          state_d = StRespCode;
          code_d  = RespTimeout;
        end else if (rx_fire && (bus.rx_data == CmdTrigger)) begin
          trigger_d = 1'b1;
        end
      end
      StDump: begin
        guard_d = (guard_q == 2'd3) ? guard_q : guard_q + 2'd1;
        // The snooper's dump_end is stale for the first two DUMP cycles.
        if ((guard_q >= 2'd2) && bus.dump_end && !bus.snoop_valid) begin
          state_d = StRespCode;
          code_d  = RespOk;
        end
      end
      StRespCode: begin
        if (tx_fire) state_d = StRespNl;
      end
      StRespNl: begin
        if (tx_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    snoop_ready = 1'b0;
    unique case (state_q)
      StDump: begin
        tx_valid    = bus.snoop_valid;
        tx_data     = bus.snoop_data;
        snoop_ready = bus.tx_ready;
      end
      StRespCode: begin
        tx_valid = 1'b1;
        tx_data  = code_q;
      end
      StRespNl: begin
        tx_valid = 1'b1;
        tx_data  = CharLf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      state_q   <= StIdle;
      code_q    <= 8'h00;
      trigger_q <= 1'b0;
      guard_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      trigger_q <= trigger_d;
      guard_q   <= guard_d;
    end
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.tx_valid       = tx_valid;
  assign bus.tx_data        = tx_data;
  assign bus.snoop_ready    = snoop_ready;
  assign bus.record_start   = in_record;
  assign bus.record_trigger = trigger_q;
  assign bus.dump_start     = (state_q == StDump);
  assign bus.busy           = (state_q != StIdle);

endmodule
